// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: FSM state codes, register offsets,
// CTRL bit positions and MODE codes.
package timer_bank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   localparam logic [1:0] REG_CTRL     = 2'd0;
   localparam logic [1:0] REG_PRESET   = 2'd1;
   localparam logic [1:0] REG_COUNT    = 2'd2;
   localparam logic [1:0] REG_PRESCALE = 2'd3;
   localparam logic [1:0] REG_STATUS   = 2'd0;

   localparam int CTRL_W       = 4;
   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_IM      = 3;
   localparam int PRESCALE_W   = 16;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_bank_channel.sv
// One down-counting timer channel: CTRL/PRESET/COUNT registers plus its FSM.
// Optional prescaler is built only when TIMER_PRESCALE_EN is defined.
module timer_bank_channel
   import timer_bank_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ctrl_wr,
   input  logic                  preset_wr,
`ifdef TIMER_PRESCALE_EN
   input  logic                  prescale_wr,
`endif
   input  logic [31:0]           din,
   output logic [CTRL_W-1:0]     ctrl,
   output logic [CNT_W-1:0]      preset,
   output logic [CNT_W-1:0]      count,
   output logic [PRESCALE_W-1:0] prescale,
   output logic                  fire
);

   state_e state, state_next;
   logic   count_ld, count_dec, en_clr, tick;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      fire       = 1'b0;
      count_ld   = 1'b0;
      count_dec  = 1'b0;
      en_clr     = 1'b0;
      case (state)
         ST_IDLE: if (ctrl[CTRL_EN]) state_next = ST_LOAD;
         ST_LOAD: begin
            count_ld   = 1'b1;
            state_next = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl[CTRL_EN])   state_next = ST_IDLE;
            else if (count == '0) state_next = ST_INT;
            else if (tick)        count_dec  = 1'b1;
         end
         ST_INT: begin
            fire = 1'b1;
            if (ctrl[CTRL_MODE_LO +: 2] == MODE_RELOAD) begin
               state_next = ST_LOAD;
            end else begin
               en_clr     = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      // A CPU CTRL write landing on the INT cycle restarts through IDLE.
      if (ctrl_wr && state == ST_INT) state_next = ST_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl   <= '0;
         preset <= '0;
         count  <= '0;
      end else begin
         if (ctrl_wr)     ctrl <= din[CTRL_W-1:0];
         else if (en_clr) ctrl[CTRL_EN] <= 1'b0;
         if (preset_wr)   preset <= din[CNT_W-1:0];
         if (count_ld)       count <= preset;
         else if (count_dec) count <= count - CNT_W'(1);
      end
   end

`ifdef TIMER_PRESCALE_EN
   logic [PRESCALE_W-1:0] psc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescale <= '0;
         psc      <= '0;
      end else begin
         if (prescale_wr) prescale <= din[PRESCALE_W-1:0];
         if (state != ST_CNT || tick) psc <= '0;
         else                         psc <= psc + PRESCALE_W'(1);
      end
   end

   assign tick = (psc == prescale);
`else
   assign prescale = '0;
   assign tick     = 1'b1;
`endif

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH timers on one word-addressed slot: decode, read mux, W1C
// pending status and IRQ vector. Optional prescaler: define TIMER_PRESCALE_EN.
module timer_bank
   import timer_bank_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 32,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] Addr,
   input  logic              WE,
   input  logic [31:0]       Din,
   output logic [31:0]       Dout,
   output logic [NUM_CH-1:0] IRQ,
   output logic              irq_any
);

   localparam int SLOT_W = ADDR_W - 2;

   logic [SLOT_W-1:0]     slot;
   logic [1:0]            regsel;
   logic [NUM_CH-1:0]     ctrl_wr, fire, im, pend, status_clr;
   logic                  status_wr;
   logic [CTRL_W-1:0]     ch_ctrl     [NUM_CH];
   logic [CNT_W-1:0]      ch_preset   [NUM_CH];
   logic [CNT_W-1:0]      ch_count    [NUM_CH];
   logic [PRESCALE_W-1:0] ch_prescale [NUM_CH];

   assign slot   = Addr[ADDR_W-1:2];
   assign regsel = Addr[1:0];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic sel;
      assign sel        = WE && (slot == SLOT_W'(i));
      assign ctrl_wr[i] = sel && (regsel == REG_CTRL);
      assign im[i]      = ch_ctrl[i][CTRL_IM];

      timer_bank_channel #(.CNT_W(CNT_W)) u_ch (
         .clk         (clk),
         .reset       (reset),
         .ctrl_wr     (ctrl_wr[i]),
         .preset_wr   (sel && (regsel == REG_PRESET)),
`ifdef TIMER_PRESCALE_EN
         .prescale_wr (sel && (regsel == REG_PRESCALE)),
`endif
         .din         (Din),
         .ctrl        (ch_ctrl[i]),
         .preset      (ch_preset[i]),
         .count       (ch_count[i]),
         .prescale    (ch_prescale[i]),
         .fire        (fire[i])
      );
   end

   assign status_wr  = WE && (slot == SLOT_W'(NUM_CH)) && (regsel == REG_STATUS);
   assign status_clr = status_wr ? Din[NUM_CH-1:0] : '0;

   // Hardware set beats both the W1C clear and the CTRL-write clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pend <= '0;
      else       pend <= (pend & ~(status_clr | ctrl_wr)) | fire;
   end

   always_comb begin
      Dout = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (slot == SLOT_W'(i)) begin
            case (regsel)
               REG_CTRL:     Dout = 32'(ch_ctrl[i]);
               REG_PRESET:   Dout = 32'(ch_preset[i]);
               REG_COUNT:    Dout = 32'(ch_count[i]);
               REG_PRESCALE: Dout = 32'(ch_prescale[i]);
               default:      Dout = '0;
            endcase
         end
      end
      if (slot == SLOT_W'(NUM_CH) && regsel == REG_STATUS) Dout = 32'(pend);
   end

   assign IRQ     = pend & im;
   assign irq_any = |IRQ;

endmodule
